// File: rtl/ieee488_dev_engine.sv
// ieee488_dev_engine: device-side IEEE-488 byte engine.
// Source (talker) and acceptor (listener) sequencers for the DAV/NRFD/NDAC
// three-wire handshake. Everything advances on the 1 MHz ce strobe. All bus
// inputs are active-low. All bus outputs are open-collector contributions,
// where 1 means released.
module ieee488_dev_engine #(
    parameter int                SETTLE_CE  = 2,
    parameter int                TO_W       = 16,
    parameter logic [TO_W-1:0]   TIMEOUT_CE = 16'd64000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        talk_en,
    input  logic        listen_en,
    input  logic [7:0]  tx_data,
    input  logic        tx_eoi,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_abort,
    output logic [7:0]  rx_data,
    output logic        rx_eoi,
    output logic        rx_atn,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_atn_i,
    input  logic        bus_eoi_i,
    input  logic        bus_dav_i,
    input  logic        bus_nrfd_i,
    input  logic        bus_ndac_i,
    output logic [7:0]  bus_data_o,
    output logic        bus_eoi_o,
    output logic        bus_dav_o,
    output logic        bus_nrfd_o,
    output logic        bus_ndac_o
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAITRDY, S_WAITACC} src_t;
    typedef enum logic [1:0] {A_IDLE, A_NRFD, A_READY, A_ACK} acc_t;

    localparam logic [TO_W-1:0] SETTLE_LAST = TO_W'((SETTLE_CE > 0) ? SETTLE_CE - 1 : 0);
    localparam logic [TO_W-1:0] TO_LAST     = TIMEOUT_CE - 1'b1;

    // ATN low means the controller is addressing devices: the talker must get off
    // the bus, and every device must listen for commands.
    logic src_act, acc_act;
    assign src_act = talk_en & bus_atn_i;
    assign acc_act = ~bus_atn_i | (listen_en & ~talk_en);

    // ---------------- source (talker) ----------------
    src_t             s_q, s_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [7:0]       txd_q, txd_d;
    logic             txe_q, txe_d;
    logic             s_accept, s_abort;

    // Source state, shared settle/timeout counter and the latched outgoing byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q   <= S_IDLE;
            cnt_q <= '0;
            txd_q <= '0;
            txe_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            cnt_q <= cnt_d;
            txd_q <= txd_d;
            txe_q <= txe_d;
        end
    end

    // Source next state. Losing talk permission always aborts, even mid-settle.
    // Otherwise a listener accept wins over a timeout that lands on the same tick.
    always_comb begin
        s_d      = s_q;
        cnt_d    = cnt_q;
        txd_d    = txd_q;
        txe_d    = txe_q;
        s_accept = 1'b0;
        s_abort  = 1'b0;
        if (ce) begin
            if (s_q != S_IDLE && !src_act) begin
                s_d     = S_IDLE;
                s_abort = 1'b1;
            end else begin
                case (s_q)
                    S_IDLE: begin
                        if (src_act && tx_valid) begin
                            txd_d = tx_data;
                            txe_d = tx_eoi;
                            s_d   = S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == SETTLE_LAST) s_d = S_WAITRDY;
                        else                      cnt_d = cnt_q + 1'b1;
                    end
                    S_WAITRDY: begin
                        if (bus_nrfd_i && !bus_ndac_i) begin
                            s_d = S_WAITACC;
                        end else if (bus_nrfd_i && bus_ndac_i) begin
                            // Both lines are released, so nobody is listening.
                            s_d     = S_IDLE;
                            s_abort = 1'b1;
                        end else if (cnt_q == TO_LAST) begin
                            s_d     = S_IDLE;
                            s_abort = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    S_WAITACC: begin
                        if (bus_ndac_i) begin
                            s_d      = S_IDLE;
                            s_accept = 1'b1;
                        end else if (cnt_q == TO_LAST) begin
                            s_d     = S_IDLE;
                            s_abort = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: s_d = S_IDLE;
                endcase
            end
            if (s_d != s_q) cnt_d = '0;
        end
    end

    // Source outputs. DIO and EOI are driven for the whole transfer, and DAV is
    // driven only while waiting for the acceptance. The pulses are combinational
    // so tx_ready coincides with the edge that returns the FSM to IDLE. This
    // stops the same byte from being sent twice when ce is high every clock.
    always_comb begin
        bus_data_o = (s_q != S_IDLE) ? ~txd_q : 8'hFF;
        bus_eoi_o  = (s_q != S_IDLE) ? ~txe_q : 1'b1;
        bus_dav_o  = (s_q != S_WAITACC);
        tx_ready   = s_accept;
        tx_abort   = s_abort;
    end

    // ---------------- acceptor (listener) ----------------
    acc_t       a_q, a_d;
    logic [7:0] rxd_q, rxd_d;
    logic       rxe_q, rxe_d;
    logic       rxa_q, rxa_d;
    logic       rxv_q, rxv_d;

    // Acceptor state and the received-byte holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= A_IDLE;
            rxd_q <= '0;
            rxe_q <= 1'b0;
            rxa_q <= 1'b0;
            rxv_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            rxd_q <= rxd_d;
            rxe_q <= rxe_d;
            rxa_q <= rxa_d;
            rxv_q <= rxv_d;
        end
    end

    // Acceptor next state. The consumer handshake runs every clock, and the bus
    // handshake runs on ce. NRFD stays low in A_NRFD until the held byte is taken.
    always_comb begin
        a_d   = a_q;
        rxd_d = rxd_q;
        rxe_d = rxe_q;
        rxa_d = rxa_q;
        rxv_d = rxv_q;
        if (rxv_q && rx_ready) rxv_d = 1'b0;
        if (ce) begin
            if (!acc_act) begin
                a_d = A_IDLE;
            end else begin
                case (a_q)
                    A_IDLE:  a_d = A_NRFD;
                    A_NRFD:  if (!rxv_q) a_d = A_READY;
                    A_READY: begin
                        if (!bus_dav_i) begin
                            rxd_d = ~bus_data_i;
                            rxe_d = ~bus_eoi_i;
                            rxa_d = ~bus_atn_i;
                            rxv_d = 1'b1;
                            a_d   = A_ACK;
                        end
                    end
                    A_ACK:   if (bus_dav_i) a_d = A_NRFD;
                    default: a_d = A_IDLE;
                endcase
            end
        end
    end

    // Acceptor outputs. NRFD is released only in A_READY, and NDAC only in A_ACK.
    always_comb begin
        bus_nrfd_o = ~(a_q == A_NRFD || a_q == A_ACK);
        bus_ndac_o = ~(a_q == A_NRFD || a_q == A_READY);
        rx_data    = rxd_q;
        rx_eoi     = rxe_q;
        rx_atn     = rxa_q;
        rx_valid   = rxv_q;
    end

endmodule
